// File: rtl/rate_tick_gen.sv
// rate_tick_gen: one-cycle tick every 1/T/2T/4T clocks, pausable, mode-reloadable.
// Define RATE_TICK_SYNC_EN to pass mode/run through two-flop synchronisers.
`timescale 1ns/1ps
module rate_tick_gen #(
    parameter int unsigned TICKS_1HZ = 50000000,
    parameter int unsigned CNT_W     = 28
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic [1:0]       mode,
    input  logic             run,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    localparam longint unsigned T64 = longint'(TICKS_1HZ);
    localparam logic [CNT_W-1:0] RLD_01 = CNT_W'(T64 - 64'd1);
    localparam logic [CNT_W-1:0] RLD_10 = CNT_W'(2 * T64 - 64'd1);
    localparam logic [CNT_W-1:0] RLD_11 = CNT_W'(4 * T64 - 64'd1);

    logic [1:0]       mode_s;
    logic             run_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             tick_q, tick_d;

`ifdef RATE_TICK_SYNC_EN
    logic [1:0] mode_m_q, mode_s_q;
    logic       run_m_q, run_s_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            mode_m_q <= 2'b00;
            mode_s_q <= 2'b00;
            run_m_q  <= 1'b0;
            run_s_q  <= 1'b0;
        end else begin
            mode_m_q <= mode;
            mode_s_q <= mode_m_q;
            run_m_q  <= run;
            run_s_q  <= run_m_q;
        end
    end

    assign mode_s = mode_s_q;
    assign run_s  = run_s_q;
`else
    assign mode_s = mode;
    assign run_s  = run;
`endif

    // Reload value is the period minus one, so a tick lands every P edges.
    function automatic logic [CNT_W-1:0] reload(input logic [1:0] m);
        logic [CNT_W-1:0] r;
        unique case (m)
            2'b00: r = '0;
            2'b01: r = RLD_01;
            2'b10: r = RLD_10;
            2'b11: r = RLD_11;
        endcase
        return r;
    endfunction

    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (mode_s != mode_q) begin
            mode_d = mode_s;
            cnt_d  = reload(mode_s);
        end else if (run_s) begin
            if (cnt_q == '0) begin
                tick_d = 1'b1;
                cnt_d  = reload(mode_q);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            mode_q <= 2'b00;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            tick_q <= tick_d;
        end
    end

    assign tick  = tick_q;
    assign count = cnt_q;

endmodule

// File: tb/tb_rate_tick_gen.sv
// tb_rate_tick_gen: directed scenarios plus a per-cycle model of rate_tick_gen.
// The model counts running edges since the last mode apply and derives outputs.
`timescale 1ns/1ps
module tb_rate_tick_gen;

    localparam int unsigned T     = 4;
    localparam int unsigned W     = 8;
`ifdef RATE_TICK_SYNC_EN
    localparam int          LAT   = 2;
`else
    localparam int          LAT   = 0;
`endif

    logic         clk = 1'b0;
    logic         resetn;
    logic [1:0]   mode;
    logic         run;
    logic         tick;
    logic [W-1:0] count;

    int errors = 0;
    int checks = 0;

    rate_tick_gen #(.TICKS_1HZ(T), .CNT_W(W)) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .mode     (mode),
        .run      (run),
        .tick     (tick),
        .count    (count)
    );

    always #5 clk = ~clk;

    function automatic int unsigned per(input logic [1:0] m);
        case (m)
            2'b00:   return 1;
            2'b01:   return T;
            2'b10:   return 2 * T;
            default: return 4 * T;
        endcase
    endfunction

    // Model: n = running edges since the mode was applied.
    int unsigned n;
    logic [1:0]  mm;
    logic        mtick;
    logic [1:0]  ms1, ms2;
    logic        rs1, rs2;

    always @(posedge clk or negedge resetn) begin
        logic [1:0] me;
        logic       re;
        if (!resetn) begin
            n = 0; mm = 2'b00; mtick = 1'b0;
            ms1 = 2'b00; ms2 = 2'b00; rs1 = 1'b0; rs2 = 1'b0;
        end else begin
`ifdef RATE_TICK_SYNC_EN
            me = ms2; re = rs2;
`else
            me = mode; re = run;
`endif
            if (me != mm) begin
                mm = me; n = 0; mtick = 1'b0;
            end else if (!re) begin
                mtick = 1'b0;
            end else begin
                n = n + 1;
                mtick = ((n % per(mm)) == 0);
            end
            ms2 = ms1; ms1 = mode; rs2 = rs1; rs1 = run;
        end
    end

    function automatic int unsigned mcount();
        return per(mm) - 1 - (n % per(mm));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_tick", int'(tick), int'(mtick));
        check("model_count", int'(count), int'(mcount()));
    end

    task automatic edge_();
        @(posedge clk);
        #2;
    endtask

    int q[$];

    initial begin
        resetn = 1'b0; mode = 2'b00; run = 1'b0;
        #1;
        check("reset_tick", int'(tick), 0);
        check("reset_count", int'(count), 0);
        edge_(); edge_();
        check("reset_hold_count", int'(count), 0);

        // Scenario 1: mode 00 ticks every edge.
        resetn = 1'b1; run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            edge_();
`ifndef RATE_TICK_SYNC_EN
            check("s1_tick", int'(tick), 1);
            check("s1_count", int'(count), 0);
`endif
        end

        // Scenario 2: 00 -> 01.
        mode = 2'b01;
        repeat (LAT) edge_();
        edge_();
        check("s2_apply_count", int'(count), 3);
        check("s2_apply_tick", int'(tick), 0);
        for (int k = 1; k <= 8; k++) begin
            edge_();
            check("s2_tick", int'(tick), (k % 4 == 0) ? 1 : 0);
            check("s2_count", int'(count), 3 - (k % 4));
        end

        // Scenario 3: periods in modes 10 and 11.
        mode = 2'b10;
        repeat (LAT + 1) edge_();
        q.delete();
        for (int k = 0; k < 40; k++) begin
            edge_();
            if (tick) q.push_back(k);
        end
        check("s3_m10_nticks_ge4", int'(q.size() >= 4), 1);
        for (int i = 1; i < q.size(); i++)
            check("s3_m10_period", q[i] - q[i-1], 8);

        mode = 2'b11;
        repeat (LAT + 1) edge_();
        q.delete();
        for (int k = 0; k < 70; k++) begin
            edge_();
            if (tick) q.push_back(k);
        end
        check("s3_m11_nticks_ge4", int'(q.size() >= 4), 1);
        for (int i = 1; i < q.size(); i++)
            check("s3_m11_period", q[i] - q[i-1], 16);

        // Scenario 4: pause while count = 2.
        mode = 2'b01;
        repeat (LAT) edge_();
        edge_();
        edge_();
`ifndef RATE_TICK_SYNC_EN
        check("s4_pre_count", int'(count), 2);
`endif
        run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            edge_();
`ifndef RATE_TICK_SYNC_EN
            check("s4_hold_count", int'(count), 2);
            check("s4_hold_tick", int'(tick), 0);
`endif
        end
        run = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            edge_();
`ifndef RATE_TICK_SYNC_EN
            check("s4_resume_tick", int'(tick), (k == 3) ? 1 : 0);
            check("s4_resume_count", int'(count), (k == 3) ? 3 : 2 - k);
`endif
        end

        // Scenario 5: mode change on the count = 0 edge.
        repeat (3) edge_();
`ifndef RATE_TICK_SYNC_EN
        check("s5_pre_count", int'(count), 0);
`endif
        mode = 2'b10;
        repeat (LAT) edge_();
        edge_();
`ifndef RATE_TICK_SYNC_EN
        check("s5_tick", int'(tick), 0);
        check("s5_count", int'(count), 7);
`endif

        // Scenario 6: asynchronous reset mid-period.
        mode = 2'b01;
        repeat (LAT) edge_();
        edge_();
        edge_(); edge_();
`ifndef RATE_TICK_SYNC_EN
        check("s6_pre_count", int'(count), 1);
`endif
        resetn = 1'b0;
        #1;
        check("s6_rst_count", int'(count), 0);
        check("s6_rst_tick", int'(tick), 0);
        #1;
        resetn = 1'b1;
        repeat (LAT) edge_();
        edge_();
        check("s6_fresh_count", int'(count), 3);
        repeat (12) edge_();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
